audio_envelope_tracker: RTL and testbench
=========================================

Name: audio_envelope_tracker

Overview:
Conditions raw XADC audio samples into a smoothed loudness envelope for the visualizer outputs. It sits between the XADC wrapper (eoc_out strobe, do_out[15:4]) and the consumers: the MOSFET PWM duty register, the LED bar chaser and the 7-segment BCD path. It computes per-sample magnitude about the mid-rail bias, takes the peak over fixed sample windows, and applies instant attack with exponential decay. It also produces a bar count and a timed peak-hold value.

Parameters:
MID, 2048, offset-binary zero level subtracted from each 12-bit sample
WIN_LOG2, 6, window length = 2^WIN_LOG2 accepted samples (legal 1..10)
DECAY_SHIFT, 3, decay step = (env - win_peak) >> DECAY_SHIFT (legal 1..8)
HOLD_WINDOWS, 32, windows peak_hold is held before releasing (legal 1..255)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high reset
sample_valid  in  1  one-cycle strobe, driven from XADC eoc_out
sample_data  in  12  unsigned sample, do_out[15:4]
drop_clr  in  1  synchronous clear of sample_drop
env_level  out  12  current envelope, 0..2048
env_valid  out  1  one-cycle pulse when env_level/bar_count/peak_hold update
bar_count  out  5  env_level >> 7, range 0..16
peak_hold  out  12  held maximum envelope
sample_drop  out  1  sticky overrun flag

Behaviour:
- Clock is clk. Reset is reset, asynchronous, active-high.
- Reset, including mid-operation: all outputs 0, state ACCUM, window count 0, win_max 0, skid register empty, hold_cnt 0. No partial window survives reset.
- Magnitude: mag = |sample_data - MID|, computed with a 13-bit signed difference. Range 0..2048, carried in 12 bits. No saturation is needed.
- FSM states: ACCUM, UPDATE, PUBLISH.
- ACCUM:
  - An accepted sample sets win_max = max(win_max, mag) and increments the window count.
  - On accepting sample number 2^WIN_LOG2, go to UPDATE. Window count and win_max reset for the next window on that same edge; the closing peak is latched as win_peak.
- UPDATE (1 cycle): compute next envelope.
  - If win_peak >= env, then env_next = win_peak (attack).
  - Otherwise d = (env - win_peak) >> DECAY_SHIFT, and env_next = env - max(d, 1).
  - Go to PUBLISH.
- PUBLISH (1 cycle):
  - Register env_level = env_next and bar_count = env_next >> 7.
  - Pulse env_valid for this cycle.
  - Update peak_hold as below, then return to ACCUM.
- Latency: env_valid is high exactly 2 cycles after the clock edge that accepts the window-closing sample.
- Peak hold:
  - If env_next >= peak_hold, then peak_hold = env_next and hold_cnt = HOLD_WINDOWS.
  - Else if hold_cnt > 0, decrement hold_cnt.
  - Else peak_hold = env_next.
- Skid buffer:
  - sample_valid during UPDATE or PUBLISH is stored in a 1-entry skid register and is not lost.
  - On the first ACCUM cycle with the skid full, the skid sample is accepted. A sample_valid arriving on that same cycle goes into the skid.
  - sample_valid while the skid is already full and cannot drain discards the new sample and sets sample_drop.
- sample_drop: sticky, cleared only by drop_clr or reset. If drop_clr and a new drop occur on the same cycle, the flag stays set.
- Sample accepted from any source during ACCUM counts toward the current window.
- Outputs hold their values between env_valid pulses. env_valid never asserts on two consecutive cycles.

Test Plan:
- Reset asserted mid-window after 20 samples of 4095, released, then 64 samples of 2048 -> all outputs 0 while in reset. One env_valid pulse with env_level=0, bar_count=0; the pre-reset samples contribute nothing.
- 64 samples of 4095 after reset -> env_valid 2 cycles after the 64th accept; env_level=2047, bar_count=15, peak_hold=2047.
- 64 samples of 0 -> env_level=2048, bar_count=16. Then windows of 2048 -> env_level sequence 1792, 1568, 1372, 1201. Then one window with win_peak=1300 -> env_level=1300 (attack). Separately, from env=7 with win_peak=0 -> env_level steps 6, 5, ..., 0 (min decrement 1).
- After env=2048, drive silent windows -> peak_hold stays 2048 for 32 env_valid pulses, then on the 33rd equals the current env_level.
- Window-closing sample followed by sample_valid in the UPDATE and PUBLISH cycles -> the UPDATE-cycle sample is kept and counted in the next window. The PUBLISH-cycle sample finds the skid full, so sample_drop=1. sample_drop stays 1 until drop_clr pulses, then 0.

Source files
------------

// File: rtl/audio_envelope_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : audio_envelope_tracker
//  Purpose  : Turns raw XADC audio samples into a smoothed loudness envelope.
//             Per-sample magnitude about the mid-rail bias, peak over fixed
//             windows of 2^WIN_LOG2 accepted samples, instant attack and
//             exponential decay, plus a bar count and a timed peak hold.
//  Ports    : clk          - system clock (100 MHz)
//             reset        - asynchronous, active-high reset
//             sample_valid - one-cycle sample strobe (XADC eoc_out)
//             sample_data  - 12-bit unsigned sample (XADC do_out[15:4])
//             drop_clr     - synchronous clear of sample_drop
//             env_level    - current envelope, 0..2048
//             env_valid    - one-cycle pulse when env_level/bar_count/peak_hold update
//             bar_count    - env_level >> 7, 0..16
//             peak_hold    - held maximum envelope
//             sample_drop  - sticky overrun flag
//  Revision : 1.0 - initial release
// ============================================================================
module audio_envelope_tracker #(
  parameter int MID          = 2048,
  parameter int WIN_LOG2     = 6,
  parameter int DECAY_SHIFT  = 3,
  parameter int HOLD_WINDOWS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [11:0] sample_data,
  input  logic        drop_clr,
  output logic [11:0] env_level,
  output logic        env_valid,
  output logic [4:0]  bar_count,
  output logic [11:0] peak_hold,
  output logic        sample_drop
);

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_UPDATE  = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  localparam logic [WIN_LOG2-1:0] CNT_LAST  = {WIN_LOG2{1'b1}};
  localparam logic [12:0]         MID13     = 13'(MID);
  localparam logic [7:0]          HOLD_INIT = 8'(HOLD_WINDOWS);

  // State registers
  logic [1:0]          state_q,       state_d;
  logic [WIN_LOG2-1:0] cnt_q,         cnt_d;
  logic [11:0]         win_max_q,     win_max_d;
  logic [11:0]         win_peak_q,    win_peak_d;
  logic [11:0]         env_next_q,    env_next_d;
  logic [11:0]         env_level_q,   env_level_d;
  logic                env_valid_q,   env_valid_d;
  logic [4:0]          bar_count_q,   bar_count_d;
  logic [11:0]         peak_hold_q,   peak_hold_d;
  logic [7:0]          hold_cnt_q,    hold_cnt_d;
  logic                skid_full_q,   skid_full_d;
  logic [11:0]         skid_data_q,   skid_data_d;
  logic                sample_drop_q, sample_drop_d;

  // Combinational helpers
  logic        acc_valid;
  logic [11:0] acc_data;
  logic [12:0] diff13;
  logic [11:0] mag;
  logic [11:0] win_max_new;
  logic [11:0] decay_diff;
  logic [11:0] decay_shr;
  logic [11:0] decay_step;
  logic        drop_new;

  // In ACCUM a waiting skid sample always goes first; a fresh strobe on the
  // same cycle then takes its place in the skid register.
  assign acc_valid = (state_q == ST_ACCUM) && (skid_full_q || sample_valid);
  assign acc_data  = skid_full_q ? skid_data_q : sample_data;

  // 13-bit signed difference about mid-rail. The largest magnitude (2048)
  // still fits in 12 bits, so the two's-complement negate is done on the low
  // 12 bits only.
  assign diff13 = {1'b0, acc_data} - MID13;
  assign mag    = diff13[12] ? (~diff13[11:0] + 12'd1) : diff13[11:0];

  assign win_max_new = (mag > win_max_q) ? mag : win_max_q;

  // Only meaningful when env_level_q > win_peak_q (decay branch).
  assign decay_diff = env_level_q - win_peak_q;
  assign decay_shr  = decay_diff >> DECAY_SHIFT;
  // A minimum step of 1 guarantees the envelope eventually reaches the peak.
  assign decay_step = (decay_shr == 12'd0) ? 12'd1 : decay_shr;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_max_d   = win_max_q;
    win_peak_d  = win_peak_q;
    env_next_d  = env_next_q;
    env_level_d = env_level_q;
    env_valid_d = 1'b0;
    bar_count_d = bar_count_q;
    peak_hold_d = peak_hold_q;
    hold_cnt_d  = hold_cnt_q;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    drop_new    = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        if (skid_full_q) begin
          skid_full_d = sample_valid;
          if (sample_valid) begin
            skid_data_d = sample_data;
          end
        end
        if (acc_valid) begin
          if (cnt_q == CNT_LAST) begin
            // Window closes: latch its peak and start the next window clean.
            win_peak_d = win_max_new;
            win_max_d  = 12'd0;
            cnt_d      = '0;
            state_d    = ST_UPDATE;
          end else begin
            win_max_d = win_max_new;
            cnt_d     = cnt_q + WIN_LOG2'(1);
          end
        end
      end

      ST_UPDATE: begin
        if (win_peak_q >= env_level_q) begin
          env_next_d = win_peak_q;
        end else begin
          env_next_d = env_level_q - decay_step;
        end
        if (sample_valid) begin
          if (skid_full_q) begin
            drop_new = 1'b1;
          end else begin
            skid_full_d = 1'b1;
            skid_data_d = sample_data;
          end
        end
        state_d = ST_PUBLISH;
      end

      ST_PUBLISH: begin
        env_level_d = env_next_q;
        bar_count_d = env_next_q[11:7];
        env_valid_d = 1'b1;
        if (env_next_q >= peak_hold_q) begin
          peak_hold_d = env_next_q;
          hold_cnt_d  = HOLD_INIT;
        end else if (hold_cnt_q != 8'd0) begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end else begin
          peak_hold_d = env_next_q;
        end
        if (sample_valid) begin
          if (skid_full_q) begin
            drop_new = 1'b1;
          end else begin
            skid_full_d = 1'b1;
            skid_data_d = sample_data;
          end
        end
        state_d = ST_ACCUM;
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // A drop on the same cycle as drop_clr wins, so no overrun is ever hidden.
  assign sample_drop_d = drop_new || (sample_drop_q && !drop_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_ACCUM;
      cnt_q         <= '0;
      win_max_q     <= 12'd0;
      win_peak_q    <= 12'd0;
      env_next_q    <= 12'd0;
      env_level_q   <= 12'd0;
      env_valid_q   <= 1'b0;
      bar_count_q   <= 5'd0;
      peak_hold_q   <= 12'd0;
      hold_cnt_q    <= 8'd0;
      skid_full_q   <= 1'b0;
      skid_data_q   <= 12'd0;
      sample_drop_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      win_max_q     <= win_max_d;
      win_peak_q    <= win_peak_d;
      env_next_q    <= env_next_d;
      env_level_q   <= env_level_d;
      env_valid_q   <= env_valid_d;
      bar_count_q   <= bar_count_d;
      peak_hold_q   <= peak_hold_d;
      hold_cnt_q    <= hold_cnt_d;
      skid_full_q   <= skid_full_d;
      skid_data_q   <= skid_data_d;
      sample_drop_q <= sample_drop_d;
    end
  end

  assign env_level   = env_level_q;
  assign env_valid   = env_valid_q;
  assign bar_count   = bar_count_q;
  assign peak_hold   = peak_hold_q;
  assign sample_drop = sample_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_envelope_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_audio_envelope_tracker
//  Purpose  : Self-checking bench for audio_envelope_tracker. A behavioural
//             model predicts each window result when its closing sample is
//             driven; a monitor pops and compares on every env_valid pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_envelope_tracker;

  localparam int WIN   = 64;
  localparam int DSH   = 3;
  localparam int HOLDW = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic        drop_clr;
  logic [11:0] env_level;
  logic        env_valid;
  logic [4:0]  bar_count;
  logic [11:0] peak_hold;
  logic        sample_drop;

  audio_envelope_tracker #(
    .MID(2048), .WIN_LOG2(6), .DECAY_SHIFT(DSH), .HOLD_WINDOWS(HOLDW)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .sample_data(sample_data), .drop_clr(drop_clr),
    .env_level(env_level), .env_valid(env_valid), .bar_count(bar_count),
    .peak_hold(peak_hold), .sample_drop(sample_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int env;
    int bar;
    int peak;
    int edge_n;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  int m_cnt, m_wmax, m_env, m_peak, m_hold;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int magnitude(int s);
    return (s >= 2048) ? (s - 2048) : (2048 - s);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_wmax = 0; m_env = 0; m_peak = 0; m_hold = 0;
  endtask

  // edge_n: index of the clock edge that accepts this sample
  task automatic model_sample(int s, int edge_n);
    int mg, nxt, d;
    exp_t e;
    mg = magnitude(s);
    if (mg > m_wmax) m_wmax = mg;
    m_cnt++;
    if (m_cnt == WIN) begin
      if (m_wmax >= m_env) nxt = m_wmax;
      else begin
        d = (m_env - m_wmax) >> DSH;
        if (d < 1) d = 1;
        nxt = m_env - d;
      end
      m_env = nxt;
      if (nxt >= m_peak) begin
        m_peak = nxt; m_hold = HOLDW;
      end else if (m_hold > 0) m_hold--;
      else m_peak = nxt;
      e.env = m_env; e.bar = m_env >> 7; e.peak = m_peak; e.edge_n = edge_n;
      sb.push_back(e);
      m_cnt = 0; m_wmax = 0;
    end
  endtask

  // One strobe every third cycle: the closing sample never meets UPDATE/PUBLISH.
  task automatic drive(int s);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = 12'(s);
    model_sample(s, cyc + 1);
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic window(int s);
    for (int i = 0; i < WIN; i++) drive(s);
  endtask

  // Scoreboard consumer
  logic prev_v = 1'b0;
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (env_valid === 1'b1) begin
      chk("env_valid_not_consecutive", {31'd0, prev_v}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_env_valid_queue_size", sb.size(), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("env_level", {20'd0, env_level}, e.env);
        chk("bar_count", {27'd0, bar_count}, e.bar);
        chk("peak_hold", {20'd0, peak_hold}, e.peak);
        chk("env_valid_latency_edge", cyc, e.edge_n + 2);
      end
    end
    prev_v = env_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sample_valid = 1'b0; sample_data = 12'd0; drop_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Full-scale window, then 20 samples of a new window and reset mid-window
    window(4095);
    for (int i = 0; i < 20; i++) drive(4095);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset_env_level",   {20'd0, env_level}, 32'd0);
    chk("reset_env_valid",   {31'd0, env_valid}, 32'd0);
    chk("reset_bar_count",   {27'd0, bar_count}, 32'd0);
    chk("reset_peak_hold",   {20'd0, peak_hold}, 32'd0);
    chk("reset_sample_drop", {31'd0, sample_drop}, 32'd0);
    chk("reset_sb_empty", sb.size(), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Silent window after reset: pre-reset samples must not contribute
    window(2048);
    // Attack to 2047, then 2048
    window(4095);
    window(0);
    // Decay 1792, 1568, 1372, 1201
    for (int w = 0; w < 4; w++) window(2048);
    // Attack to 1300
    window(2048 + 1300);
    // Peak hold: back to 2048, then silent windows past the hold time
    window(0);
    for (int w = 0; w < HOLDW + 3; w++) window(2048);

    // Minimum decrement: env 7 decays 6..0
    @(negedge clk);
    #2 reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    window(2055);
    for (int w = 0; w < 8; w++) window(2048);

    // Skid buffer and overrun
    chk("drop_before_skid", {31'd0, sample_drop}, 32'd0);
    for (int i = 0; i < WIN - 1; i++) drive(2048);
    @(negedge clk);
    sample_valid = 1'b1; sample_data = 12'd2048;   // window-closing sample
    model_sample(2048, cyc + 1);
    @(negedge clk);
    sample_data = 12'd4095;                         // UPDATE cycle -> skid
    model_sample(4095, cyc + 1);
    @(negedge clk);
    sample_data = 12'd0;                            // PUBLISH cycle -> dropped
    @(negedge clk);
    sample_valid = 1'b0;
    chk("drop_set", {31'd0, sample_drop}, 32'd1);
    repeat (5) @(negedge clk);
    chk("drop_sticky", {31'd0, sample_drop}, 32'd1);
    for (int i = 0; i < WIN - 1; i++) drive(2048);
    chk("drop_sticky_late", {31'd0, sample_drop}, 32'd1);
    @(negedge clk);
    drop_clr = 1'b1;
    @(negedge clk);
    drop_clr = 1'b0;
    chk("drop_cleared", {31'd0, sample_drop}, 32'd0);

    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
